// File: rtl/of_drain_serializer.sv
// Output-feature-map drain: buffers whole systolic-array result rows and
// serializes them one signed word per beat over a valid/ready stream.
module of_drain_serializer #(
    parameter int SYS_COLS   = 4,
    parameter int P_BITWIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int RELU_EN    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           in_valid,
    input  logic [SYS_COLS*P_BITWIDTH-1:0] in_row,
    output logic                           in_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [P_BITWIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic [$clog2(DEPTH):0]         row_count,
    output logic                           drop_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;
    localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST_COL   = CW'(SYS_COLS - 1);

    logic [SYS_COLS*P_BITWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]                  wr_ptr;
    logic [PW-1:0]                  rd_ptr;
    logic [CW-1:0]                  col_idx;
    logic signed [P_BITWIDTH-1:0]   head_word;
    logic                           push;
    logic                           beat;
    logic                           row_pop;

    function automatic logic signed [P_BITWIDTH-1:0] relu(input logic signed [P_BITWIDTH-1:0] w);
        return (RELU_EN != 0 && w < 0) ? '0 : w;
    endfunction

    // Flow control looks only at registered state, so a same-cycle pop never frees a slot.
    assign in_ready  = (row_count < FULL_COUNT);
    assign out_valid = (row_count != '0);
    assign out_last  = out_valid && (col_idx == LAST_COL);
    assign push      = in_valid && in_ready && !clr;
    assign beat      = out_valid && out_ready && !clr;
    assign row_pop   = beat && out_last;

    assign head_word = mem[rd_ptr][col_idx*P_BITWIDTH +: P_BITWIDTH];
    assign out_data  = relu(head_word);

    // Storage is cleared on reset so out_data reads zero until the first row lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= in_row;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            col_idx   <= '0;
            row_count <= '0;
            drop_err  <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            col_idx   <= '0;
            row_count <= '0;
            drop_err  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (row_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (beat)
                col_idx <= out_last ? '0 : col_idx + 1'b1;
            if (in_valid && !in_ready)
                drop_err <= 1'b1;
            case ({push, row_pop})
                2'b10:   row_count <= row_count + 1'b1;
                2'b01:   row_count <= row_count - 1'b1;
                default: row_count <= row_count;
            endcase
        end
    end

endmodule

// File: tb/tb_of_drain_serializer.sv
// Randomized bench for of_drain_serializer: a word-queue reference model
// predicts every output; a RELU_EN=1 twin shares the same stimulus.
module tb_of_drain_serializer;

    localparam int SC = 4;
    localparam int PB = 32;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clr = 1'b0;
    logic            in_valid = 1'b0;
    logic [SC*PB-1:0] in_row = '0;
    logic            out_ready = 1'b0;
    logic            in_ready, out_valid, out_last, drop_err;
    logic [PB-1:0]   out_data;
    logic [2:0]      row_count;
    logic            r_in_ready, r_out_valid, r_out_last, r_drop_err;
    logic [PB-1:0]   r_out_data;
    logic [2:0]      r_row_count;

    of_drain_serializer #(.SYS_COLS(SC), .P_BITWIDTH(PB), .DEPTH(D), .RELU_EN(0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_row(in_row),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .row_count(row_count), .drop_err(drop_err)
    );

    of_drain_serializer #(.SYS_COLS(SC), .P_BITWIDTH(PB), .DEPTH(D), .RELU_EN(1)) dut_relu (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_row(in_row),
        .in_ready(r_in_ready), .out_valid(r_out_valid), .out_ready(out_ready),
        .out_data(r_out_data), .out_last(r_out_last), .row_count(r_row_count), .drop_err(r_drop_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: every buffered word in drain order, plus the sticky drop flag.
    logic [PB-1:0] q[$];
    bit            m_drop;
    logic [6:0]    exp_ctl;
    logic [PB-1:0] exp_data, exp_relu;
    logic          exp_valid;

    function automatic int m_rows();
        return (q.size() + SC - 1) / SC;
    endfunction

    function automatic void update_exp();
        int rows;
        rows      = m_rows();
        exp_valid = (q.size() != 0);
        exp_data  = exp_valid ? q[0] : '0;
        exp_relu  = exp_data[PB-1] ? '0 : exp_data;
        exp_ctl   = {exp_valid, exp_valid && ((q.size() - 1) % SC == 0), 3'(rows), rows < D, m_drop};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_drop = 1'b0;
        update_exp();
    endfunction

    task automatic tick();
        bit acc, pop;
        acc = in_valid && (m_rows() < D) && !clr;
        pop = out_ready && (q.size() != 0) && !clr;
        @(posedge clk);
        if (clr) begin
            q.delete();
            m_drop = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (in_valid && !acc) m_drop = 1'b1;
            if (acc) for (int c = 0; c < SC; c++) q.push_back(in_row[c*PB +: PB]);
        end
        #1;
        update_exp();
    endtask

    function automatic logic [SC*PB-1:0] rand_row();
        logic [SC*PB-1:0] r;
        for (int c = 0; c < SC; c++) r[c*PB +: PB] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_last, row_count, in_ready, drop_err, out_data} !== {7'b00_000_10, 32'd0}) begin
            errors++;
            $display("FAIL reset_hold got %b/%h exp 0000010/0", {out_valid, out_last, row_count, in_ready, drop_err}, out_data);
        end
        #2 rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if ({out_valid, out_last, row_count, in_ready, drop_err} !== exp_ctl) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", {out_valid, out_last, row_count, in_ready, drop_err}, exp_ctl);
        end
    endtask

    task automatic test_single_row();
        in_row    = {32'd4, 32'd3, 32'd2, 32'd1};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < SC; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(k + 1) || out_last !== (k == SC - 1)) begin
                errors++;
                $display("FAIL single_word%0d got v%b d%0d l%b exp v1 d%0d l%0d", k, out_valid, out_data, out_last, k + 1, k == SC - 1);
            end
            checks++;
            if ({out_valid, out_last, row_count, in_ready, drop_err} !== exp_ctl || out_data !== exp_data) begin
                errors++;
                $display("FAIL single_model got %b/%h exp %b/%h", {out_valid, out_last, row_count, in_ready, drop_err}, out_data, exp_ctl, exp_data);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || row_count !== 3'd0) begin
            errors++;
            $display("FAIL single_empty got v%b cnt%0d exp v0 cnt0", out_valid, row_count);
        end
    endtask

    task automatic test_fill_overflow();
        out_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            in_row   = rand_row();
            in_valid = 1'b1;
            tick();
            checks++;
            if ({out_valid, out_last, row_count, in_ready, drop_err} !== exp_ctl || out_data !== exp_data) begin
                errors++;
                $display("FAIL fill_row%0d got %b/%h exp %b/%h", r, {out_valid, out_last, row_count, in_ready, drop_err}, out_data, exp_ctl, exp_data);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (row_count !== 3'd4 || in_ready !== 1'b0 || drop_err !== 1'b1) begin
            errors++;
            $display("FAIL fill_full got cnt%0d rdy%b drop%b exp cnt4 rdy0 drop1", row_count, in_ready, drop_err);
        end
        out_ready = 1'b1;
        for (int k = 0; k < D * SC; k++) begin
            checks++;
            if ({out_valid, out_last, row_count, in_ready, drop_err} !== exp_ctl || out_data !== exp_data) begin
                errors++;
                $display("FAIL drain_word%0d got %b/%h exp %b/%h", k, {out_valid, out_last, row_count, in_ready, drop_err}, out_data, exp_ctl, exp_data);
            end
            tick();
        end
    endtask

    task automatic test_push_pop_full();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (D) begin
            in_row = rand_row();
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (SC - 1) tick();
        in_valid = 1'b1;
        in_row   = rand_row();
        checks++;
        if (in_ready !== 1'b0 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_setup got rdy%b last%b exp rdy0 last1", in_ready, out_last);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (row_count !== 3'd3 || drop_err !== 1'b1 || {out_valid, out_last, row_count, in_ready, drop_err} !== exp_ctl) begin
            errors++;
            $display("FAIL full_pop got cnt%0d drop%b exp cnt3 drop1", row_count, drop_err);
        end
        repeat (SC - 1) tick();
        in_valid = 1'b1;
        in_row   = rand_row();
        tick();
        in_valid = 1'b0;
        checks++;
        if (row_count !== 3'd3 || {out_valid, out_last, row_count, in_ready, drop_err} !== exp_ctl) begin
            errors++;
            $display("FAIL push_pop_same got cnt%0d exp cnt3", row_count);
        end
        for (int k = 0; k < 3 * SC; k++) begin
            checks++;
            if ({out_valid, out_last, row_count, in_ready, drop_err} !== exp_ctl || out_data !== exp_data) begin
                errors++;
                $display("FAIL pp_drain%0d got %b/%h exp %b/%h", k, {out_valid, out_last, row_count, in_ready, drop_err}, out_data, exp_ctl, exp_data);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int            pushed;
        bit            was_stall;
        logic [PB-1:0] held;
        logic [3:0]    pat;
        pushed = 0;
        pat    = 4'b1001;
        for (int cyc = 0; cyc < 400 && (pushed < 3 * D || exp_valid); cyc++) begin
            in_valid  = (pushed < 3 * D) && ($urandom_range(0, 2) != 0);
            in_row    = rand_row();
            out_ready = (cyc < 16) ? pat[3 - (cyc % 4)] : 1'($urandom_range(0, 1));
            if (in_valid && m_rows() < D) pushed++;
            was_stall = out_valid && !out_ready;
            held      = out_data;
            tick();
            checks++;
            if ({out_valid, out_last, row_count, in_ready, drop_err} !== exp_ctl ||
                (exp_valid && (out_data !== exp_data || r_out_data !== exp_relu))) begin
                errors++;
                $display("FAIL bp_cyc%0d got %b/%h/%h exp %b/%h/%h", cyc, {out_valid, out_last, row_count, in_ready, drop_err},
                         out_data, r_out_data, exp_ctl, exp_data, exp_relu);
            end
            if (was_stall) begin
                checks++;
                if (out_data !== held) begin
                    errors++;
                    $display("FAIL bp_stall_hold got %h exp %h", out_data, held);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_clr_and_rst();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (2) begin
            in_row = rand_row();
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_row   = rand_row();
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || row_count !== 3'd0 || drop_err !== 1'b0 || {out_valid, out_last, row_count, in_ready, drop_err} !== exp_ctl) begin
            errors++;
            $display("FAIL clr_flush got v%b cnt%0d drop%b exp v0 cnt0 drop0", out_valid, row_count, drop_err);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || row_count !== 3'd0) begin
            errors++;
            $display("FAIL clr_discard got v%b cnt%0d exp v0 cnt0", out_valid, row_count);
        end
        in_valid  = 1'b1;
        out_ready = 1'b0;
        repeat (D + 1) begin
            in_row = rand_row();
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, row_count, in_ready, drop_err} !== 7'b00_000_10 || out_data !== '0 || r_out_data !== '0) begin
            errors++;
            $display("FAIL async_rst got %b/%h exp 0000010/0", {out_valid, out_last, row_count, in_ready, drop_err}, out_data);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if ({out_valid, out_last, row_count, in_ready, drop_err} !== exp_ctl || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst got %b exp %b", {out_valid, out_last, row_count, in_ready, drop_err}, exp_ctl);
        end
    endtask

    task automatic test_relu();
        logic [PB-1:0] exp_seq [SC];
        exp_seq   = '{32'd0, 32'd7, 32'd0, 32'd0};
        in_row    = {32'd0, 32'h8000_0000, 32'd7, -32'sd5};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < SC; k++) begin
            checks++;
            if (r_out_valid !== 1'b1 || r_out_data !== exp_seq[k] || out_data !== exp_data) begin
                errors++;
                $display("FAIL relu_word%0d got %h raw %h exp %h raw %h", k, r_out_data, out_data, exp_seq[k], exp_data);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_row();
        test_fill_overflow();
        test_push_pop_full();
        test_backpressure();
        test_clr_and_rst();
        test_relu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached exp finish");
        $fatal(1, "timeout");
    end

endmodule
